multicycle_ctrl_fsm: RTL and testbench

//  Next-generation multicycle MIPS control unit: registered Moore FSM that sequences fetch, decode,

---
 rtl/multicycle_ctrl_fsm.sv | 253 +++++++++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle MIPS control unit: registered Moore FSM with parametrised memory latency,
// branch resolution and illegal-opcode trap. Optional performance counters: CTRL_PERF_CNT_EN.
module multicycle_ctrl_fsm #(
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             zero,
    output logic             memread,
    output logic             memwrite,
    output logic             IorD,
    output logic             IR_write,
    output logic             alusrcA,
    output logic [1:0]       alusrcB,
    output logic [1:0]       toaluctrl,
    output logic [1:0]       pcsrc,
    output logic             pc_write,
    output logic             pc_write_condition,
    output logic             pc_en,
    output logic             regwrite,
    output logic [1:0]       regdst,
    output logic [1:0]       memtoreg,
    output logic             illegal_op,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);
    // state    | meaning
    // FETCH    | read instruction, PC+4 (MEM_LAT cycles)
    // DECODE   | branch target precompute, dispatch on opcode
    // EXEC     | ALU op for R/addi/andi
    // ALUWB    | write ALU result to register file
    // MEMADR   | effective address for lw/sw
    // MEMRD    | data read (MEM_LAT cycles)
    // MEMWB    | write loaded data to register file
    // MEMWR    | data write (MEM_LAT cycles)
    // BRANCH   | beq/bne compare and conditional PC load
    // JUMP     | j
    // JR       | jr
    // JAL      | jal, link PC+4 into $31
    localparam int LAT_W = $clog2(MEM_LAT + 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT - 1);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_JR   = 6'b000001;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_EXEC  = 4'd2,  S_ALUWB = 4'd3,
        S_MEMADR = 4'd4,  S_MEMRD  = 4'd5,  S_MEMWB = 4'd6,  S_MEMWR = 4'd7,
        S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_JR    = 4'd10, S_JAL   = 4'd11
    } state_t;

    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic       iord;
        logic       ir_write;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       pc_write;
        logic       pc_wc;
        logic       regwrite;
        logic [1:0] regdst;
        logic [1:0] memtoreg;
    } ctrl_t;

    // Outputs are a pure function of the state being entered, so they can be registered.
    function automatic ctrl_t decode_ctrl(state_t s, logic [LAT_W-1:0] lat, logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.memread = 1'b1;
                c.alusrcb = 2'b01;
                if (lat == LAT_LAST) begin
                    c.ir_write = 1'b1;
                    c.pc_write = 1'b1;
                end
            end
            S_DECODE: c.alusrcb = 2'b11;
            S_EXEC: begin
                c.alusrca = 1'b1;
                case (op)
                    OP_ADDI: c.alusrcb = 2'b10;
                    OP_ANDI: begin
                        c.alusrcb = 2'b10;
                        c.aluop   = 2'b11;
                    end
                    default: c.aluop = 2'b10;
                endcase
            end
            S_ALUWB: begin
                c.regwrite = 1'b1;
                c.regdst   = (op == OP_R) ? 2'b01 : 2'b00;
            end
            S_MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            S_MEMRD: begin
                c.memread = 1'b1;
                c.iord    = 1'b1;
            end
            S_MEMWB: begin
                c.regwrite = 1'b1;
                c.memtoreg = 2'b01;
            end
            S_MEMWR: begin
                c.memwrite = 1'b1;
                c.iord     = 1'b1;
            end
            S_BRANCH: begin
                c.alusrca = 1'b1;
                c.aluop   = 2'b01;
                c.pcsrc   = 2'b01;
                c.pc_wc   = 1'b1;
            end
            S_JUMP: begin
                c.pc_write = 1'b1;
                c.pcsrc    = 2'b10;
            end
            S_JR: begin
                c.pc_write = 1'b1;
                c.pcsrc    = 2'b11;
            end
            S_JAL: begin
                c.pc_write = 1'b1;
                c.pcsrc    = 2'b10;
                c.regwrite = 1'b1;
                c.regdst   = 2'b10;
                c.memtoreg = 2'b10;
            end
            default: ;
        endcase
        return c;
    endfunction

    state_t           state, nxt_state;
    logic [LAT_W-1:0] lat_cnt, nxt_lat;
    logic             trap;
    ctrl_t            ctrl_q;
    logic             ill_q;

    always_comb begin
        nxt_state = S_FETCH;
        nxt_lat   = '0;
        trap      = 1'b0;
        case (state)
            S_FETCH: begin
                if (lat_cnt == LAT_LAST) begin
                    nxt_state = S_DECODE;
                end else begin
                    nxt_state = S_FETCH;
                    nxt_lat   = lat_cnt + LAT_W'(1);
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_R, OP_ADDI, OP_ANDI: nxt_state = S_EXEC;
                    OP_LW, OP_SW:           nxt_state = S_MEMADR;
                    OP_BEQ, OP_BNE:         nxt_state = S_BRANCH;
                    OP_J:                   nxt_state = S_JUMP;
                    OP_JAL:                 nxt_state = S_JAL;
                    OP_JR:                  nxt_state = S_JR;
                    default: begin
                        nxt_state = S_FETCH;
                        trap      = 1'b1;
                    end
                endcase
            end
            S_EXEC:   nxt_state = S_ALUWB;
            S_MEMADR: nxt_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (lat_cnt == LAT_LAST) begin
                    nxt_state = S_MEMWB;
                end else begin
                    nxt_state = S_MEMRD;
                    nxt_lat   = lat_cnt + LAT_W'(1);
                end
            end
            S_MEMWR: begin
                if (lat_cnt != LAT_LAST) begin
                    nxt_state = S_MEMWR;
                    nxt_lat   = lat_cnt + LAT_W'(1);
                end
            end
            default: nxt_state = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_FETCH;
            lat_cnt <= '0;
            ctrl_q  <= decode_ctrl(S_FETCH, '0, OP_R);
            ill_q   <= 1'b0;
        end else begin
            state   <= nxt_state;
            lat_cnt <= nxt_lat;
            ctrl_q  <= decode_ctrl(nxt_state, nxt_lat, opcode);
            if (trap) ill_q <= 1'b1;
        end
    end

    // ctrl_q holds FETCH values during reset so the first post-reset cycle drives them at once.
    assign memread            = ctrl_q.memread  & reset;
    assign memwrite           = ctrl_q.memwrite & reset;
    assign IorD               = ctrl_q.iord     & reset;
    assign IR_write           = ctrl_q.ir_write & reset;
    assign alusrcA            = ctrl_q.alusrca  & reset;
    assign alusrcB            = ctrl_q.alusrcb  & {2{reset}};
    assign toaluctrl          = ctrl_q.aluop    & {2{reset}};
    assign pcsrc              = ctrl_q.pcsrc    & {2{reset}};
    assign pc_write           = ctrl_q.pc_write & reset;
    assign pc_write_condition = ctrl_q.pc_wc    & reset;
    assign regwrite           = ctrl_q.regwrite & reset;
    assign regdst             = ctrl_q.regdst   & {2{reset}};
    assign memtoreg           = ctrl_q.memtoreg & {2{reset}};
    assign illegal_op         = ill_q;
    assign pc_en = (ctrl_q.pc_write | (ctrl_q.pc_wc & (zero ^ (opcode == OP_BNE)))) & reset;

`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] cyc_q, ins_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_q <= '0;
            ins_q <= '0;
        end else begin
            cyc_q <= cyc_q + CNT_W'(1);
            if (nxt_state == S_FETCH && state != S_FETCH) ins_q <= ins_q + CNT_W'(1);
        end
    end

    assign cycle_cnt = cyc_q;
    assign instr_cnt = ins_q;
`else
    assign cycle_cnt = '0;
    assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm (MEM_LAT=3): stimulus pushes per-cycle expected
// control vectors, a negedge monitor pops and compares them.
module tb_multicycle_ctrl_fsm;
    localparam int ML = 3;

    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic       iord;
        logic       ir_write;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       pc_write;
        logic       pc_wc;
        logic       pc_en;
        logic       regwrite;
        logic [1:0] regdst;
        logic [1:0] memtoreg;
        logic       illegal;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  opcode = 6'b0;
    logic        zero = 1'b0;
    logic        memread, memwrite, iord, ir_write, alusrca, pc_write, pc_wc, pc_en, regwrite, illegal_op;
    logic [1:0]  alusrcb, aluop, pcsrc, regdst, memtoreg;
    logic [31:0] cycle_cnt, instr_cnt;

    int   total = 0;
    int   bad = 0;
    exp_t expq[$];
    string tagq[$];
    logic ill_exp = 1'b0;
    int   n_instr = 0;
    logic [31:0] cyc_model = 0;

    multicycle_ctrl_fsm #(.MEM_LAT(ML), .CNT_W(32)) dut (
        .clk(clk), .reset(rst), .opcode(opcode), .zero(zero),
        .memread(memread), .memwrite(memwrite), .IorD(iord), .IR_write(ir_write),
        .alusrcA(alusrca), .alusrcB(alusrcb), .toaluctrl(aluop), .pcsrc(pcsrc),
        .pc_write(pc_write), .pc_write_condition(pc_wc), .pc_en(pc_en),
        .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
        .illegal_op(illegal_op), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst)
        if (!rst) cyc_model <= 0;
        else      cyc_model <= cyc_model + 1;

    always @(negedge clk) begin
        exp_t  act, e;
        string t;
        act = {memread, memwrite, iord, ir_write, alusrca, alusrcb, aluop, pcsrc,
               pc_write, pc_wc, pc_en, regwrite, regdst, memtoreg, illegal_op};
        if (expq.size() != 0) begin
            e = expq.pop_front();
            t = tagq.pop_front();
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL %s got=%h exp=%h", t, act, e);
            end
        end
    end

    function automatic exp_t base();
        exp_t e = '0;
        e.illegal = ill_exp;
        return e;
    endfunction

    task automatic push(input exp_t e, input string t);
        expq.push_back(e);
        tagq.push_back(t);
    endtask

    task automatic push_fetch(input string t);
        exp_t e;
        for (int i = 0; i < ML; i++) begin
            e = base(); e.memread = 1; e.alusrcb = 2'b01;
            if (i == ML - 1) begin e.ir_write = 1; e.pc_write = 1; e.pc_en = 1; end
            push(e, {t, "/fetch"});
        end
        e = base(); e.alusrcb = 2'b11;
        push(e, {t, "/decode"});
    endtask

    task automatic drain();
        int n = 0;
        while (expq.size() != 0 && n < 100) begin @(posedge clk); n++; end
        if (expq.size() != 0) begin
            total++; bad++;
            $display("FAIL drain_timeout pending=%0d required=0", expq.size());
            expq.delete(); tagq.delete();
        end
        #1;
    endtask

    // Called one step after the edge that entered FETCH; returns likewise.
    task automatic run(input logic [5:0] op, input logic z, input string t);
        exp_t e;
        opcode = op; zero = z;
        push_fetch(t);
        case (op)
            6'b000000, 6'b001000, 6'b001100: begin
                e = base(); e.alusrca = 1;
                if (op == 6'b000000)      e.aluop = 2'b10;
                else if (op == 6'b001000) e.alusrcb = 2'b10;
                else begin e.alusrcb = 2'b10; e.aluop = 2'b11; end
                push(e, {t, "/exec"});
                e = base(); e.regwrite = 1; e.regdst = (op == 6'b000000) ? 2'b01 : 2'b00;
                push(e, {t, "/aluwb"});
            end
            6'b100011, 6'b101011: begin
                e = base(); e.alusrca = 1; e.alusrcb = 2'b10;
                push(e, {t, "/memadr"});
                for (int i = 0; i < ML; i++) begin
                    e = base(); e.iord = 1;
                    if (op == 6'b100011) e.memread = 1; else e.memwrite = 1;
                    push(e, {t, "/mem"});
                end
                if (op == 6'b100011) begin
                    e = base(); e.regwrite = 1; e.memtoreg = 2'b01;
                    push(e, {t, "/memwb"});
                end
            end
            6'b000100, 6'b000101: begin
                e = base(); e.alusrca = 1; e.aluop = 2'b01; e.pcsrc = 2'b01; e.pc_wc = 1;
                e.pc_en = (op == 6'b000100) ? z : ~z;
                push(e, {t, "/branch"});
            end
            6'b000010: begin
                e = base(); e.pc_write = 1; e.pc_en = 1; e.pcsrc = 2'b10;
                push(e, {t, "/jump"});
            end
            6'b000001: begin
                e = base(); e.pc_write = 1; e.pc_en = 1; e.pcsrc = 2'b11;
                push(e, {t, "/jr"});
            end
            6'b000011: begin
                e = base(); e.pc_write = 1; e.pc_en = 1; e.pcsrc = 2'b10;
                e.regwrite = 1; e.regdst = 2'b10; e.memtoreg = 2'b10;
                push(e, {t, "/jal"});
            end
            default: ill_exp = 1'b1;
        endcase
        drain();
        n_instr++;
    endtask

    task automatic reset_cycle(input string t);
        exp_t e = '0;
        rst = 1'b0;
        ill_exp = 1'b0;
        push(e, t);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        n_instr = 0;
    endtask

    initial begin
        exp_t e;
        int n;
        e = '0;
        push(e, "reset0");
        push(e, "reset1");
        @(posedge clk); @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;

        // lw interrupted by reset during its first MEMRD cycle
        opcode = 6'b100011;
        push_fetch("lw_abort");
        e = '0; e.alusrca = 1; e.alusrcb = 2'b10; push(e, "lw_abort/memadr");
        e = '0; e.memread = 1; e.iord = 1;        push(e, "lw_abort/memrd");
        n = 0;
        while (expq.size() != 0 && n < 100) begin @(negedge clk); #1; n++; end
        reset_cycle("abort_reset");

        run(6'b000000, 1'b0, "add");
        run(6'b001000, 1'b0, "addi");
        run(6'b001100, 1'b0, "andi");
        run(6'b000100, 1'b1, "beq_z1");
        run(6'b000100, 1'b0, "beq_z0");
        run(6'b000101, 1'b0, "bne_z0");
        run(6'b000101, 1'b1, "bne_z1");
        run(6'b100011, 1'b0, "lw");
        run(6'b101011, 1'b0, "sw");
        run(6'b000010, 1'b0, "j");
        run(6'b000001, 1'b0, "jr");
        run(6'b000011, 1'b0, "jal");
        run(6'b111111, 1'b0, "illegal");
        run(6'b000000, 1'b0, "add_after_trap");

        total++;
`ifdef CTRL_PERF_CNT_EN
        if (instr_cnt !== 32'(n_instr)) begin
            bad++; $display("FAIL instr_cnt got=%0d exp=%0d", instr_cnt, n_instr);
        end
        total++;
        if (cycle_cnt !== cyc_model) begin
            bad++; $display("FAIL cycle_cnt got=%0d exp=%0d", cycle_cnt, cyc_model);
        end
`else
        if (instr_cnt !== 32'd0) begin
            bad++; $display("FAIL instr_cnt_tied got=%0d exp=0", instr_cnt);
        end
        total++;
        if (cycle_cnt !== 32'd0) begin
            bad++; $display("FAIL cycle_cnt_tied got=%0d exp=0", cycle_cnt);
        end
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout time=%0t limit=200000", $time);
        $fatal(1, "timeout");
    end
endmodule
